// File: rtl/arbiter_client.sv
// arbiter_client: queues producer payloads and presents them to a shared arbiter.
// It flags starvation after TIMEOUT ungranted cycles and flags grants that arrive while the queue is idle.
module arbiter_client #(
  parameter int DW      = 32,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic [DW-1:0]           in_data,
  output logic                    in_ready,
  output logic                    request,
  input  logic                    grant,
  output logic                    out_valid,
  output logic [DW-1:0]           out_data,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    starved,
  output logic                    err_grant
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [15:0] TO = 16'(TIMEOUT);
  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [15:0]   wait_q, wait_d;
  logic          ov_q, ov_d, err_q, err_d;
  logic [DW-1:0] od_q, od_d;
  logic          push, pop;
  assign in_ready  = cnt_q < FULL;
  assign request   = cnt_q != '0;
  assign push      = in_valid & in_ready;
  assign pop       = grant & request;
  assign out_valid = ov_q;
  assign out_data  = od_q;
  assign count     = cnt_q;
  assign starved   = wait_q == TO;
  assign err_grant = err_q;
  always_comb begin
    wr_d   = push ? wr_q + AW'(1) : wr_q;
    rd_d   = pop ? rd_q + AW'(1) : rd_q;
    cnt_d  = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    ov_d   = pop;
    od_d   = pop ? mem_q[rd_q] : od_q;
    err_d  = err_q | (grant & ~request);
    // the wait counter only runs while a request is outstanding and ungranted
    wait_d = (pop || !request) ? '0 : (wait_q == TO ? wait_q : wait_q + 16'd1);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      wait_q <= '0;
      ov_q   <= 1'b0;
      od_q   <= '0;
      err_q  <= 1'b0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      wait_q <= wait_d;
      ov_q   <= ov_d;
      od_q   <= od_d;
      err_q  <= err_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push && !reset) mem_q[wr_q] <= in_data;
  end
endmodule

// File: tb/tb_arbiter_client.sv
// tb_arbiter_client: directed bench for arbiter_client with DW=8, DEPTH=4, TIMEOUT=3.
module tb_arbiter_client;
  logic       clk = 1'b0;
  logic       reset, in_valid, grant;
  logic [7:0] in_data;
  logic       in_ready, request, out_valid, starved, err_grant;
  logic [7:0] out_data;
  logic [2:0] count;
  int checks = 0;
  int errors = 0;

  arbiter_client #(.DW(8), .DEPTH(4), .TIMEOUT(3)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .request(request), .grant(grant),
    .out_valid(out_valid), .out_data(out_data), .count(count),
    .starved(starved), .err_grant(err_grant)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; grant = 1'b0;
    tick(); tick();
    chk("rst_count", 32'(count), 0);
    chk("rst_request", 32'(request), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_starved", 32'(starved), 0);
    chk("rst_err", 32'(err_grant), 0);
    reset = 1'b0;
    // three pushes, one idle cycle, then grant held for three cycles
    in_valid = 1'b1; in_data = 8'h11; tick();
    chk("p1_count", 32'(count), 1);
    chk("p1_request", 32'(request), 1);
    in_data = 8'h22; tick();
    in_data = 8'h33; tick();
    chk("p3_count", 32'(count), 3);
    in_valid = 1'b0; tick();
    chk("p3_starved", 32'(starved), 1);
    grant = 1'b1; tick();
    chk("g1_valid", 32'(out_valid), 1);
    chk("g1_data", 32'(out_data), 32'h11);
    chk("g1_count", 32'(count), 2);
    chk("g1_starved", 32'(starved), 0);
    tick();
    chk("g2_data", 32'(out_data), 32'h22);
    chk("g2_valid", 32'(out_valid), 1);
    tick();
    chk("g3_data", 32'(out_data), 32'h33);
    chk("g3_count", 32'(count), 0);
    chk("g3_request", 32'(request), 0);
    grant = 1'b0; tick();
    chk("g4_valid", 32'(out_valid), 0);
    chk("g4_hold", 32'(out_data), 32'h33);
    chk("g4_err", 32'(err_grant), 0);
    // fill to full, fifth value held off until a pop frees a slot
    in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_data = 8'(i); tick();
    end
    chk("full_count", 32'(count), 4);
    chk("full_ready", 32'(in_ready), 0);
    in_data = 8'h05; tick();
    chk("full_blocked", 32'(count), 4);
    grant = 1'b1; tick();
    chk("full_pop_data", 32'(out_data), 32'h01);
    chk("full_pop_count", 32'(count), 3);
    chk("full_pop_ready", 32'(in_ready), 1);
    grant = 1'b0; tick();
    chk("fifth_count", 32'(count), 4);
    in_valid = 1'b0; grant = 1'b1;
    for (int i = 2; i <= 5; i++) begin
      tick();
      chk("drain_data", 32'(out_data), 32'(i));
      chk("drain_valid", 32'(out_valid), 1);
    end
    chk("drain_count", 32'(count), 0);
    grant = 1'b0; tick();
    // simultaneous push and pop with a single entry
    in_valid = 1'b1; in_data = 8'h77; tick();
    in_data = 8'hAA; grant = 1'b1; tick();
    chk("pp_data", 32'(out_data), 32'h77);
    chk("pp_count", 32'(count), 1);
    chk("pp_request", 32'(request), 1);
    in_valid = 1'b0; tick();
    chk("pp_next", 32'(out_data), 32'hAA);
    chk("pp_empty", 32'(count), 0);
    grant = 1'b0; tick();
    // starvation with TIMEOUT=3
    in_valid = 1'b1; in_data = 8'h5A; tick();
    in_valid = 1'b0;
    tick(); chk("st_w1", 32'(starved), 0);
    tick(); chk("st_w2", 32'(starved), 0);
    tick(); chk("st_w3", 32'(starved), 1);
    tick(); chk("st_hold", 32'(starved), 1);
    grant = 1'b1; tick();
    chk("st_clear", 32'(starved), 0);
    chk("st_data", 32'(out_data), 32'h5A);
    grant = 1'b0; tick();
    // grant on an empty queue
    chk("eg_pre", 32'(err_grant), 0);
    grant = 1'b1; tick();
    chk("eg_set", 32'(err_grant), 1);
    chk("eg_novalid", 32'(out_valid), 0);
    grant = 1'b0; tick();
    chk("eg_sticky", 32'(err_grant), 1);
    reset = 1'b1; tick();
    chk("eg_reset", 32'(err_grant), 0);
    reset = 1'b0;
    // reset with queued entries; push and grant during reset are ignored
    in_valid = 1'b1;
    in_data = 8'hC1; tick();
    in_data = 8'hC2; tick();
    in_data = 8'hC3; tick();
    chk("mr_count3", 32'(count), 3);
    reset = 1'b1; in_data = 8'hEE; grant = 1'b1; tick();
    chk("mr_count", 32'(count), 0);
    chk("mr_request", 32'(request), 0);
    chk("mr_valid", 32'(out_valid), 0);
    chk("mr_data", 32'(out_data), 0);
    reset = 1'b0; grant = 1'b0; in_data = 8'h99; tick();
    chk("mr_push", 32'(count), 1);
    in_valid = 1'b0; grant = 1'b1; tick();
    chk("mr_fresh", 32'(out_data), 32'h99);
    chk("mr_fresh_valid", 32'(out_valid), 1);
    grant = 1'b0; tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/arbiter_client.md
ARBITER_CLIENT -- requirements
Module: arbiter_client

Interface
REQ-001 Parameter DW, default 32, payload width in bits.
REQ-002 Parameter DEPTH, default 4, queue entries; power of two, 2..16.
REQ-003 Parameter TIMEOUT, default 255, starvation threshold in cycles; range 1..65535.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  producer offers in_data this cycle.
REQ-007 in_data  input  DW  producer payload.
REQ-008 in_ready  output  1  queue can accept; push = in_valid & in_ready.
REQ-009 request  output  1  request line to the shared arbiter's requests bit.
REQ-010 grant  input  1  one-hot grant bit returned by the arbiter for this client.
REQ-011 out_valid  output  1  one-cycle pulse: out_data holds the granted payload.
REQ-012 out_data  output  DW  granted payload, registered.
REQ-013 count  output  $clog2(DEPTH)+1  current queue occupancy.
REQ-014 starved  output  1  request pending without grant for TIMEOUT cycles.
REQ-015 err_grant  output  1  sticky: grant seen while request low.

Function
REQ-016 Queue is a circular buffer with registered write/read pointers wrapping modulo DEPTH and a registered count.
REQ-017 in_ready SHALL equal (count < DEPTH), combinational from registered count; no push-through when full.
REQ-018 request SHALL equal (count != 0), combinational from registered count; request rises the cycle after the first push into an empty queue.
REQ-019 pop = grant & request; a pop removes the head entry at the clock edge.
REQ-020 On pop, out_data SHALL load the head entry and out_valid SHALL be 1 for exactly the next cycle (latency 1 from grant); otherwise out_valid 0 and out_data holds its value.
REQ-021 Push and pop in the same cycle: both take effect, count unchanged; when count==DEPTH, push is blocked by in_ready=0 even if a pop occurs.
REQ-022 Push and pop in the same cycle with count==1: the old head is popped, the new entry becomes head, request stays 1.
REQ-023 Grant asserted for consecutive cycles pops one entry per cycle until empty; grant while count==0 pops nothing.
REQ-024 Grant while request==0 SHALL set err_grant to 1 from the next cycle; err_grant is cleared only by reset.
REQ-025 Wait counter (16 bits): cleared on pop or when request==0; otherwise increments each cycle, saturating at TIMEOUT.
REQ-026 starved SHALL be 1 while wait counter == TIMEOUT and clears the cycle after a pop or after the queue empties.
REQ-027 FIFO ordering: payloads leave on out_data in exact push order; no loss, no duplication.
REQ-028 count SHALL never exceed DEPTH nor underflow below 0.

Reset
REQ-029 While reset is high at a clock edge: pointers, count, wait counter cleared; out_valid=0, out_data=0, starved=0, err_grant=0; hence request=0, in_ready=1 after the edge.
REQ-030 Reset mid-operation discards all queued entries; pushes and grants in the reset cycle are ignored; a pending out_valid pulse is cancelled.
REQ-031 First push accepted on the first edge with reset low.

Verification
REQ-032 DW=8, DEPTH=4: push 0x11,0x22,0x33 on cycles 1-3, grant held cycles 5-7 -> out_valid on cycles 6,7,8 with 0x11,0x22,0x33; request low from cycle 8; count 0.
REQ-033 Push 5 values with grant low -> 4 accepted, in_ready=0 at count=4, 5th held by producer; one grant -> in_ready=1 next cycle and the 5th value is accepted.
REQ-034 count=1, simultaneous push 0xAA and grant -> out_data=old head, count stays 1, request stays 1, next grant yields 0xAA.
REQ-035 TIMEOUT=3: push one value, grant low -> starved=1 on the 3rd cycle after request rises and stays 1; grant -> starved=0 the cycle after.
REQ-036 Empty queue, grant pulse -> err_grant=1 next cycle and persists, no out_valid; reset -> err_grant=0.
REQ-037 Queue holding 3 entries, reset for 1 cycle -> count=0, request=0, out_valid=0; the next push and grant return the new value, not stale data.
